// File: rtl/ms_time_entry_if.sv
// ms_time_entry_if: keypad, control and timer-counter signals of the MM:SS entry front end.
//   master : keypad/control side; drives keys, start, stop_clear and timer_zero
//   slave  : the entry block; drives the digit outputs, digit_count, load, enab,
//            done and entry_err
interface ms_time_entry_if;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       start;
    logic       stop_clear;
    logic       timer_zero;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [2:0] digit_count;
    logic       load;
    logic       enab;
    logic       done;
    logic       entry_err;

    modport master (
        output key_valid, key_digit, start, stop_clear, timer_zero,
        input  min_tens, min_ones, sec_tens, sec_ones, digit_count,
               load, enab, done, entry_err
    );

    modport slave (
        input  key_valid, key_digit, start, stop_clear, timer_zero,
        output min_tens, min_ones, sec_tens, sec_ones, digit_count,
               load, enab, done, entry_err
    );
endinterface

// File: rtl/ms_time_entry.sv
// ms_time_entry: microwave-style MM:SS keypad entry and timer control.
// Digits shift in at seconds-ones; start validates the entry, pulses load low for one
// cycle, then enables the timer counters until timer_zero, pause or cancel.
// Ports:
//   i_clk   : system clock, rising edge
//   i_clear : asynchronous active-low reset
//   io_bus  : ms_time_entry_if.slave (keys, start/stop_clear, timer_zero in;
//             digits, digit_count, load, enab, done, entry_err out; all registered)
module ms_time_entry (
    input  logic           i_clk,
    input  logic           i_clear,
    ms_time_entry_if.slave io_bus
);

    typedef enum logic [2:0] {
        StIdle,
        StEntry,
        StLoad,
        StRun,
        StPause
    } state_e;

    state_e      r_state;
    state_e      w_state_d;
    // {min_tens, min_ones, sec_tens, sec_ones}
    logic [15:0] r_digits;
    logic [15:0] w_digits_d;
    logic [2:0]  r_count;
    logic [2:0]  w_count_d;
    logic        r_load;
    logic        w_load_d;
    logic        r_enab;
    logic        w_enab_d;
    logic        r_done;
    logic        w_done_d;
    logic        r_err;
    logic        w_err_d;

    logic        w_key_ok;
    logic        w_bad_start;

    assign w_key_ok    = io_bus.key_valid && (io_bus.key_digit <= 4'd9) && (r_count < 3'd4);
    // Seconds-tens above 5 is not a valid time; an all-zero entry has nothing to run.
    assign w_bad_start = (r_digits[7:4] > 4'd5) || (r_digits == 16'h0000);

    always_comb begin
        w_state_d  = r_state;
        w_digits_d = r_digits;
        w_count_d  = r_count;
        w_done_d   = 1'b0;
        w_err_d    = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_key_ok) begin
                    w_digits_d = {r_digits[11:0], io_bus.key_digit};
                    w_count_d  = r_count + 3'd1;
                    w_state_d  = StEntry;
                end
            end
            StEntry: begin
                if (io_bus.stop_clear) begin
                    w_digits_d = '0;
                    w_count_d  = '0;
                    w_state_d  = StIdle;
                end else if (io_bus.start) begin
                    if (w_bad_start) begin
                        w_err_d = 1'b1;
                    end else begin
                        w_state_d = StLoad;
                    end
                end else if (w_key_ok) begin
                    w_digits_d = {r_digits[11:0], io_bus.key_digit};
                    w_count_d  = r_count + 3'd1;
                end
            end
            StLoad: begin
                w_state_d = StRun;
            end
            StRun: begin
                if (io_bus.timer_zero) begin
                    w_digits_d = '0;
                    w_count_d  = '0;
                    w_done_d   = 1'b1;
                    w_state_d  = StIdle;
                end else if (io_bus.stop_clear) begin
                    w_state_d = StPause;
                end
            end
            StPause: begin
                if (io_bus.stop_clear) begin
                    w_digits_d = '0;
                    w_count_d  = '0;
                    w_state_d  = StIdle;
                end else if (io_bus.start) begin
                    w_state_d = StRun;
                end
            end
            default: begin
                w_state_d  = StIdle;
                w_digits_d = '0;
                w_count_d  = '0;
            end
        endcase

        // Control outputs follow the next state so they are registered yet aligned with it.
        w_load_d = (w_state_d != StLoad);
        w_enab_d = (w_state_d == StRun);
    end

    always_ff @(posedge i_clk or negedge i_clear) begin
        if (!i_clear) begin
            r_state  <= StIdle;
            r_digits <= '0;
            r_count  <= '0;
            r_load   <= 1'b1;
            r_enab   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_digits <= w_digits_d;
            r_count  <= w_count_d;
            r_load   <= w_load_d;
            r_enab   <= w_enab_d;
            r_done   <= w_done_d;
            r_err    <= w_err_d;
        end
    end

    assign io_bus.min_tens    = r_digits[15:12];
    assign io_bus.min_ones    = r_digits[11:8];
    assign io_bus.sec_tens    = r_digits[7:4];
    assign io_bus.sec_ones    = r_digits[3:0];
    assign io_bus.digit_count = r_count;
    assign io_bus.load        = r_load;
    assign io_bus.enab        = r_enab;
    assign io_bus.done        = r_done;
    assign io_bus.entry_err   = r_err;

endmodule

// File: tb/tb_ms_time_entry.sv
// Bench for ms_time_entry: directed scenarios with hand-derived expectations, then a
// randomized run checked against a queue-of-digits behavioural model.
module tb_ms_time_entry;

    logic clk;
    logic clear;
    int   n_tests;
    int   n_fail;

    ms_time_entry_if bus ();

    ms_time_entry dut (
        .i_clk   (clk),
        .i_clear (clear),
        .io_bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] disp;
    assign disp = {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};

    // Behavioural model: mode plus the list of entered digits (oldest first).
    localparam int MIdle  = 0;
    localparam int MEntry = 1;
    localparam int MLoad  = 2;
    localparam int MRun   = 3;
    localparam int MPause = 4;

    int m_mode;
    int m_q[$];
    bit m_done;
    bit m_err;

    function automatic int model_value();
        int v;
        v = 0;
        foreach (m_q[i]) v = v * 10 + m_q[i];
        return v;
    endfunction

    function automatic logic [15:0] model_disp();
        int v;
        v = model_value();
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_mode = MIdle;
        m_q.delete();
        m_done = 0;
        m_err  = 0;
    endtask

    task automatic model_step(input bit kv, input int kd, input bit st, input bit sc,
                              input bit tz);
        int v;
        bit key_ok;
        m_done = 0;
        m_err  = 0;
        key_ok = kv && (kd <= 9) && (m_q.size() < 4);
        case (m_mode)
            MIdle: begin
                if (key_ok) begin
                    m_q.push_back(kd);
                    m_mode = MEntry;
                end
            end
            MEntry: begin
                if (sc) begin
                    m_q.delete();
                    m_mode = MIdle;
                end else if (st) begin
                    v = model_value();
                    if (v == 0 || ((v / 10) % 10) > 5) m_err = 1;
                    else m_mode = MLoad;
                end else if (key_ok) begin
                    m_q.push_back(kd);
                end
            end
            MLoad: m_mode = MRun;
            MRun: begin
                if (tz) begin
                    m_q.delete();
                    m_done = 1;
                    m_mode = MIdle;
                end else if (sc) begin
                    m_mode = MPause;
                end
            end
            MPause: begin
                if (sc) begin
                    m_q.delete();
                    m_mode = MIdle;
                end else if (st) begin
                    m_mode = MRun;
                end
            end
            default: m_mode = MIdle;
        endcase
    endtask

    // One clock of stimulus: inputs applied at the falling edge, outputs settled 1 after rise.
    task automatic tick(input bit kv, input logic [3:0] kd, input bit st, input bit sc,
                        input bit tz);
        @(negedge clk);
        bus.key_valid  = kv;
        bus.key_digit  = kd;
        bus.start      = st;
        bus.stop_clear = sc;
        bus.timer_zero = tz;
        @(posedge clk);
        model_step(kv, int'(kd), st, sc, tz);
        #1;
        bus.key_valid  = 1'b0;
        bus.key_digit  = 4'd0;
        bus.start      = 1'b0;
        bus.stop_clear = 1'b0;
        bus.timer_zero = 1'b0;
    endtask

    task automatic key(input logic [3:0] d);
        tick(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle_cycle();
        tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        clear = 1'b0;
        #12;
        n_tests++;
        if ({disp, bus.digit_count} !== {16'h0000, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_digits: got %h/%0d expected 0000/0", disp, bus.digit_count);
        end
        n_tests++;
        if ({bus.load, bus.enab, bus.done, bus.entry_err} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 1000",
                     {bus.load, bus.enab, bus.done, bus.entry_err});
        end
        @(negedge clk);
        clear = 1'b1;
        model_reset();
    endtask

    task automatic test_basic_run();
        key(4'd1);
        key(4'd3);
        key(4'd0);
        n_tests++;
        if (disp !== 16'h0130 || bus.digit_count !== 3'd3) begin
            n_fail++;
            $display("FAIL basic_entry: got %h/%0d expected 0130/3", disp, bus.digit_count);
        end
        tick(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if ({bus.load, bus.enab} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_load_low: got load/enab %b expected 00", {bus.load, bus.enab});
        end
        idle_cycle();
        n_tests++;
        if ({bus.load, bus.enab} !== 2'b11 || disp !== 16'h0130) begin
            n_fail++;
            $display("FAIL basic_run: got load/enab %b disp %h expected 11 0130",
                     {bus.load, bus.enab}, disp);
        end
        tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if ({bus.done, bus.enab} !== 2'b10 || disp !== 16'h0000) begin
            n_fail++;
            $display("FAIL basic_done: got done/enab %b disp %h expected 10 0000",
                     {bus.done, bus.enab}, disp);
        end
        idle_cycle();
        n_tests++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_width: got %b expected 0", bus.done);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) key(4'(i));
        n_tests++;
        if (disp !== 16'h1234 || bus.digit_count !== 3'd4) begin
            n_fail++;
            $display("FAIL overflow: got %h/%0d expected 1234/4", disp, bus.digit_count);
        end
        tick(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        key(4'd12);
        n_tests++;
        if (disp !== 16'h0000 || bus.digit_count !== 3'd0) begin
            n_fail++;
            $display("FAIL bad_digit_idle: got %h/%0d expected 0000/0", disp, bus.digit_count);
        end
        key(4'd8);
        key(4'd15);
        n_tests++;
        if (disp !== 16'h0008 || bus.digit_count !== 3'd1) begin
            n_fail++;
            $display("FAIL bad_digit_entry: got %h/%0d expected 0008/1", disp, bus.digit_count);
        end
        tick(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_entry_err();
        key(4'd7);
        key(4'd5);
        tick(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if ({bus.entry_err, bus.load, bus.enab} !== 3'b110 || disp !== 16'h0075) begin
            n_fail++;
            $display("FAIL err_pulse: got err/load/enab %b disp %h expected 110 0075",
                     {bus.entry_err, bus.load, bus.enab}, disp);
        end
        tick(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (bus.entry_err !== 1'b1 || bus.load !== 1'b1) begin
            n_fail++;
            $display("FAIL err_back_to_back: got err/load %b expected 11",
                     {bus.entry_err, bus.load});
        end
        idle_cycle();
        n_tests++;
        if (bus.entry_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_width: got %b expected 0", bus.entry_err);
        end
        tick(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (disp !== 16'h0000 || bus.digit_count !== 3'd0) begin
            n_fail++;
            $display("FAIL err_cancel: got %h/%0d expected 0000/0", disp, bus.digit_count);
        end
        key(4'd0);
        key(4'd0);
        tick(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (bus.digit_count !== 3'd2 || bus.entry_err !== 1'b1 || bus.load !== 1'b1) begin
            n_fail++;
            $display("FAIL err_all_zero: got cnt %0d err/load %b expected 2 11",
                     bus.digit_count, {bus.entry_err, bus.load});
        end
        tick(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_pause_resume();
        key(4'd5);
        tick(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idle_cycle();
        tick(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if ({bus.enab, bus.load} !== 2'b01 || disp !== 16'h0005) begin
            n_fail++;
            $display("FAIL pause: got enab/load %b disp %h expected 01 0005",
                     {bus.enab, bus.load}, disp);
        end
        tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if ({bus.enab, bus.done} !== 2'b00 || disp !== 16'h0005) begin
            n_fail++;
            $display("FAIL pause_ignores_zero: got enab/done %b disp %h expected 00 0005",
                     {bus.enab, bus.done}, disp);
        end
        tick(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if ({bus.enab, bus.load} !== 2'b11) begin
            n_fail++;
            $display("FAIL resume: got enab/load %b expected 11", {bus.enab, bus.load});
        end
        tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if ({bus.done, bus.enab} !== 2'b10 || disp !== 16'h0000) begin
            n_fail++;
            $display("FAIL resume_done: got done/enab %b disp %h expected 10 0000",
                     {bus.done, bus.enab}, disp);
        end
        idle_cycle();
    endtask

    task automatic test_simultaneous();
        key(4'd4);
        key(4'd2);
        tick(1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (bus.load !== 1'b0 || disp !== 16'h0042 || bus.digit_count !== 3'd2) begin
            n_fail++;
            $display("FAIL start_beats_key: got load %b disp %h cnt %0d expected 0 0042 2",
                     bus.load, disp, bus.digit_count);
        end
        idle_cycle();
        tick(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        n_tests++;
        if ({bus.done, bus.enab} !== 2'b10 || disp !== 16'h0000) begin
            n_fail++;
            $display("FAIL zero_beats_stop: got done/enab %b disp %h expected 10 0000",
                     {bus.done, bus.enab}, disp);
        end
        // Back in idle: a key must start a new entry.
        key(4'd9);
        n_tests++;
        if (disp !== 16'h0009 || bus.digit_count !== 3'd1) begin
            n_fail++;
            $display("FAIL after_done_idle: got %h/%0d expected 0009/1", disp, bus.digit_count);
        end
        tick(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        key(4'd3);
        tick(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idle_cycle();
        @(negedge clk);
        #2;
        clear = 1'b0;
        #1;
        n_tests++;
        if ({bus.enab, bus.load, bus.done} !== 3'b010 || disp !== 16'h0000) begin
            n_fail++;
            $display("FAIL async_reset: got enab/load/done %b disp %h expected 010 0000",
                     {bus.enab, bus.load, bus.done}, disp);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.done !== 1'b0 || bus.digit_count !== 3'd0) begin
            n_fail++;
            $display("FAIL async_reset_no_done: got done %b cnt %0d expected 0 0",
                     bus.done, bus.digit_count);
        end
        @(negedge clk);
        clear = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        bit          kv;
        bit          st;
        bit          sc;
        bit          tz;
        logic [3:0]  kd;
        logic [15:0] exp_disp;
        for (int n = 0; n < 1500; n++) begin
            kv = ($urandom_range(0, 99) < 45);
            kd = 4'($urandom_range(0, 11));
            st = ($urandom_range(0, 99) < 15);
            sc = ($urandom_range(0, 99) < 6);
            tz = ($urandom_range(0, 99) < 10);
            tick(kv, kd, st, sc, tz);
            exp_disp = model_disp();
            n_tests++;
            if (disp !== exp_disp || bus.digit_count !== 3'(m_q.size())) begin
                n_fail++;
                $display("FAIL rand_digits[%0d]: got %h/%0d expected %h/%0d", n, disp,
                         bus.digit_count, exp_disp, m_q.size());
            end
            n_tests++;
            if ({bus.load, bus.enab, bus.done, bus.entry_err} !==
                {m_mode != MLoad, m_mode == MRun, m_done, m_err}) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: got load/enab/done/err %b expected %b", n,
                         {bus.load, bus.enab, bus.done, bus.entry_err},
                         {m_mode != MLoad, m_mode == MRun, m_done, m_err});
            end
        end
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        clear          = 1'b0;
        bus.key_valid  = 1'b0;
        bus.key_digit  = 4'd0;
        bus.start      = 1'b0;
        bus.stop_clear = 1'b0;
        bus.timer_zero = 1'b0;
        model_reset();
        test_reset();
        test_basic_run();
        test_overflow();
        test_entry_err();
        test_pause_resume();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
